hit_speed_estimator: RTL and testbench

- Sits directly upstream of the game controller in the pong-style video pipeline.
- Consumes the per-frame hand/paddle centroid from the camera object tracker and the live ball position from the game controller.
- Produces the `collision_detected` pulse and the `estimated_speed` word that the controller uses to bounce the ball and rescale its step period.
- Speed is a moving average of per-frame centroid displacement. Collision is a box test of the ball against the centroid, followed by a frame-counted cooldown.

---
 rtl/game_pkg.sv | 27 ++
 rtl/speed_avg4.sv | 32 +++
 rtl/hit_speed_estimator.sv | 131 +++++++++++++
 tb/tb_hit_speed_estimator.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the pong hit / speed path.
// Optional feature macro consumed by users of this package: HIT_DIR_GATE_EN.
package game_pkg;

    typedef enum logic {
        ARMED    = 1'b0,
        COOLDOWN = 1'b1
    } hit_state_t;

    localparam int SCREEN_W      = 640;
    localparam int SCREEN_H      = 480;
    localparam int COORD_W       = 10;

    localparam int HIT_RX_DEF    = 24;
    localparam int HIT_RY_DEF    = 24;
    localparam int COOLDOWN_DEF  = 8;
    localparam int MAX_SPEED_DEF = 64;

    // |a - b| through an 11-bit signed intermediate, so no wrap-around.
    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        logic signed [COORD_W:0] t;
        t = $signed({1'b0, a}) - $signed({1'b0, b});
        abs_diff = t[COORD_W] ? COORD_W'(-t) : t[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/speed_avg4.sv
// 4-tap moving average of per-frame displacement. Running sum avoids an
// adder tree; speed_valid rises once four samples are in the window.
module speed_avg4 import game_pkg::*; (
    input  logic               clk_25MHZ,
    input  logic               reset_n,
    input  logic               push,
    input  logic [COORD_W-1:0] d,
    output logic [COORD_W-1:0] avg,
    output logic               speed_valid
);

    logic [3:0][COORD_W-1:0] hist;
    logic [11:0]             sum;
    logic [2:0]              fill;

    // Shift in the new sample, retire the oldest from the running sum.
    always_ff @(posedge clk_25MHZ or negedge reset_n) begin
        if (!reset_n) begin
            hist <= '0;
            sum  <= '0;
            fill <= '0;
        end else if (push) begin
            hist <= {hist[2:0], d};
            sum  <= sum + {2'b00, d} - {2'b00, hist[3]};
            fill <= (fill == 3'd4) ? fill : fill + 3'd1;
        end
    end

    assign avg         = sum[11:2];
    assign speed_valid = (fill == 3'd4);

endmodule

// File: rtl/hit_speed_estimator.sv
// Paddle hit detector and paddle speed estimator for the pong controller.
// Define HIT_DIR_GATE_EN to only accept hits on a ball moving left.
module hit_speed_estimator import game_pkg::*; #(
    parameter int HIT_RX          = HIT_RX_DEF,
    parameter int HIT_RY          = HIT_RY_DEF,
    parameter int COOLDOWN_FRAMES = COOLDOWN_DEF,
    parameter int MAX_SPEED       = MAX_SPEED_DEF
) (
    input  logic               clk_25MHZ,
    input  logic               reset_n,
    input  logic               obj_valid,
    input  logic               obj_found,
    input  logic [COORD_W-1:0] obj_x,
    input  logic [COORD_W-1:0] obj_y,
    input  logic [COORD_W-1:0] ball_x,
    input  logic [COORD_W-1:0] ball_y,
    input  logic               is_ball_moving_left,
    output logic               collision_detected,
    output logic [COORD_W-1:0] estimated_speed,
    output logic               speed_valid
);

    localparam int CW = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [COORD_W-1:0] RX   = COORD_W'(HIT_RX);
    localparam logic [COORD_W-1:0] RY   = COORD_W'(HIT_RY);
    localparam logic [COORD_W-1:0] MAXS = COORD_W'(MAX_SPEED);
    localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);

    logic [COORD_W-1:0] pos_x, pos_y;
    logic               pos_ok, prev_ok;
    logic [COORD_W:0]   d_sum;
    logic [COORD_W-1:0] d_sat, d_q;
    logic               push_q;
    logic [COORD_W-1:0] avg, avg_clamped;
    logic               in_box, hit;

    hit_state_t         state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic               coll_n;
    logic [COORD_W-1:0] speed_n;

    // Manhattan displacement against the last found centroid, saturated.
    assign d_sum = {1'b0, abs_diff(obj_x, pos_x)} + {1'b0, abs_diff(obj_y, pos_y)};
    assign d_sat = d_sum[COORD_W] ? '1 : d_sum[COORD_W-1:0];

    // Latch centroid, track sample continuity, stage displacement for the averager.
    always_ff @(posedge clk_25MHZ or negedge reset_n) begin
        if (!reset_n) begin
            pos_x   <= '0;
            pos_y   <= '0;
            pos_ok  <= 1'b0;
            prev_ok <= 1'b0;
            push_q  <= 1'b0;
            d_q     <= '0;
        end else begin
            push_q <= obj_valid & obj_found & prev_ok;
            d_q    <= d_sat;
            if (obj_valid) begin
                if (obj_found) begin
                    pos_x   <= obj_x;
                    pos_y   <= obj_y;
                    pos_ok  <= 1'b1;
                    prev_ok <= 1'b1;
                end else begin
                    pos_ok  <= 1'b0;
                    prev_ok <= 1'b0;
                end
            end
        end
    end

    speed_avg4 u_avg (
        .clk_25MHZ   (clk_25MHZ),
        .reset_n     (reset_n),
        .push        (push_q),
        .d           (d_q),
        .avg         (avg),
        .speed_valid (speed_valid)
    );

    assign avg_clamped = (avg < ONE) ? ONE : (avg > MAXS) ? MAXS : avg;

    // Box test uses the registered centroid, so a same-cycle sample lands next cycle.
    assign in_box = pos_ok && (abs_diff(ball_x, pos_x) <= RX) && (abs_diff(ball_y, pos_y) <= RY);
`ifdef HIT_DIR_GATE_EN
    assign hit = in_box & is_ball_moving_left;
`else
    logic unused_dir;
    assign unused_dir = is_ball_moving_left;
    assign hit = in_box;
`endif

    // Next state: fire on hit, then ignore a fixed number of frames.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        coll_n  = 1'b0;
        speed_n = estimated_speed;
        case (state)
            ARMED: begin
                if (hit) begin
                    coll_n  = 1'b1;
                    speed_n = speed_valid ? avg_clamped : ONE;
                    state_n = COOLDOWN;
                    cnt_n   = CW'(COOLDOWN_FRAMES);
                end
            end
            COOLDOWN: begin
                if (cnt == '0)     state_n = ARMED;
                else if (obj_valid) cnt_n  = cnt - 1'b1;
            end
            default: state_n = ARMED;
        endcase
    end

    // FSM and output registers.
    always_ff @(posedge clk_25MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state              <= ARMED;
            cnt                <= '0;
            collision_detected <= 1'b0;
            estimated_speed    <= ONE;
        end else begin
            state              <= state_n;
            cnt                <= cnt_n;
            collision_detected <= coll_n;
            estimated_speed    <= speed_n;
        end
    end

endmodule

// File: tb/tb_hit_speed_estimator.sv
// Bench for hit_speed_estimator: frame table, corner sequences, random vs model.
module tb_hit_speed_estimator;

`ifdef HIT_DIR_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    logic       clk_25MHZ = 1'b0;
    logic       reset_n   = 1'b0;
    logic       obj_valid = 1'b0;
    logic       obj_found = 1'b0;
    logic [9:0] obj_x = '0, obj_y = '0, ball_x = '0, ball_y = '0;
    logic       is_ball_moving_left = 1'b1;
    logic       collision_detected;
    logic [9:0] estimated_speed;
    logic       speed_valid;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    hit_speed_estimator dut (
        .clk_25MHZ           (clk_25MHZ),
        .reset_n             (reset_n),
        .obj_valid           (obj_valid),
        .obj_found           (obj_found),
        .obj_x               (obj_x),
        .obj_y               (obj_y),
        .ball_x              (ball_x),
        .ball_y              (ball_y),
        .is_ball_moving_left (is_ball_moving_left),
        .collision_detected  (collision_detected),
        .estimated_speed     (estimated_speed),
        .speed_valid         (speed_valid)
    );

    always #20 clk_25MHZ = ~clk_25MHZ;

    // ---------------- reference model ----------------
    int  m_px, m_py;
    bit  m_pok, m_prevok;
    int  win[$];
    bit  pend_v;
    int  pend_d;
    bit  m_armed;
    int  m_ignore;
    int  m_coll, m_speed;

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_px = 0; m_py = 0; m_pok = 0; m_prevok = 0;
        win.delete(); pend_v = 0; pend_d = 0;
        m_armed = 1; m_ignore = 0; m_coll = 0; m_speed = 1;
    endtask

    // One clock edge of the behavioural model, using pre-edge state.
    task automatic model_step();
        int s, avg, nd;
        bit full, hit;
        full = (win.size() == 4);
        s = 0;
        foreach (win[i]) s += win[i];
        avg = s / 4;
        hit = m_armed && m_pok && iabs(int'(ball_x) - m_px) <= 24 && iabs(int'(ball_y) - m_py) <= 24;
        if (GATE) hit = hit && is_ball_moving_left;
        m_coll = hit ? 1 : 0;
        if (hit) m_speed = full ? ((avg < 1) ? 1 : (avg > 64) ? 64 : avg) : 1;
        if (m_armed) begin
            if (hit) begin m_armed = 0; m_ignore = 8; end
        end else if (m_ignore == 0) m_armed = 1;
        else if (obj_valid) m_ignore--;
        if (pend_v) begin
            win.push_back(pend_d);
            if (win.size() > 4) void'(win.pop_front());
        end
        pend_v = obj_valid && obj_found && m_prevok;
        nd = iabs(int'(obj_x) - m_px) + iabs(int'(obj_y) - m_py);
        pend_d = (nd > 1023) ? 1023 : nd;
        if (obj_valid) begin
            if (obj_found) begin
                m_px = int'(obj_x); m_py = int'(obj_y); m_pok = 1; m_prevok = 1;
            end else begin
                m_pok = 0; m_prevok = 0;
            end
        end
    endtask

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock, then compare DUT with the model.
    task automatic cycle();
        if (!reset_n) model_reset();
        else model_step();
        @(posedge clk_25MHZ);
        #1;
        pulses += int'(collision_detected);
        check("model_coll",  int'(collision_detected), m_coll);
        check("model_speed", int'(estimated_speed), m_speed);
        check("model_valid", int'(speed_valid), (win.size() == 4) ? 1 : 0);
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_coll"},  int'(collision_detected), 0);
        check({tag, "_speed"}, int'(estimated_speed), 1);
        check({tag, "_valid"}, int'(speed_valid), 0);
    endtask

    // Asynchronous reset asserted away from the edge; outputs must clear at once.
    task automatic async_reset(string tag);
        reset_n = 1'b0;
        obj_valid = 1'b0;
        model_reset();
        #1;
        check_reset_vals(tag);
        repeat (2) cycle();
        reset_n = 1'b1;
    endtask

    task automatic frame(bit f, int x, int y);
        obj_found = f; obj_x = 10'(x); obj_y = 10'(y);
        obj_valid = 1'b1;
        cycle();
        obj_valid = 1'b0;
        repeat (3) cycle();
    endtask

    // ---------------- frame table ----------------
    typedef struct {
        bit v, f;
        int ox, oy, bx, by;
        int e_coll, e_speed, e_valid;
    } row_t;

    row_t tbl[$];

    function automatic row_t mk(bit v, bit f, int ox, int oy, int bx, int by,
                                int ec, int es, int ev);
        row_t r;
        r.v = v; r.f = f; r.ox = ox; r.oy = oy; r.bx = bx; r.by = by;
        r.e_coll = ec; r.e_speed = es; r.e_valid = ev;
        return r;
    endfunction

    initial begin
        // Fill the window with d=8, then hit with avg 8.
        tbl.push_back(mk(1,1,100,200,620,20, 0, 1,0));
        tbl.push_back(mk(1,1,108,200,620,20, 0, 1,0));
        tbl.push_back(mk(1,1,116,200,620,20, 0, 1,0));
        tbl.push_back(mk(1,1,124,200,620,20, 0, 1,0));
        tbl.push_back(mk(1,1,132,200,620,20, 0, 1,1));
        tbl.push_back(mk(0,0,  0,  0,120,205, 1, 8,1));
        // Ball stays in the box for eight frames of cooldown (d=12 each).
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(1,1,(i % 2 == 0) ? 144 : 132,200,120,205, 0, 8,1));
        tbl.push_back(mk(1,1,132,200,120,205, 1,12,1));
        // d=300 frames, then a hit saturates to 64.
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1,1,(i % 2 == 0) ? 432 : 132,200,620,20, 0,12,1));
        tbl.push_back(mk(0,0,  0,  0,130,210, 1,64,1));
        // Lost frame between 100 and 400 must not push d=300.
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1,1,132,200,620,20, 0,64,1));
        tbl.push_back(mk(1,1,100,200,620,20, 0,64,1));
        tbl.push_back(mk(1,0,  0,  0,620,20, 0,64,1));
        tbl.push_back(mk(1,1,400,200,620,20, 0,64,1));
        tbl.push_back(mk(1,1,408,200,620,20, 0,64,1));
        // Lost frame blocks hits until the next found frame.
        tbl.push_back(mk(1,0,  0,  0,620,20, 0,64,1));
        tbl.push_back(mk(0,0,  0,  0,408,200,0,64,1));
        tbl.push_back(mk(1,1,408,200,408,200,1,10,1));

        // Idle after reset release.
        model_reset();
        repeat (3) @(posedge clk_25MHZ);
        #1;
        check_reset_vals("reset");
        reset_n = 1'b1;
        ball_x = '0; ball_y = '0;
        for (int i = 0; i < 1000; i++) begin
            cycle();
            check("idle_coll",  int'(collision_detected), 0);
            check("idle_speed", int'(estimated_speed), 1);
            check("idle_valid", int'(speed_valid), 0);
        end

        // Table: one frame strobe plus four quiet cycles per row.
        foreach (tbl[r]) begin
            ball_x = 10'(tbl[r].bx); ball_y = 10'(tbl[r].by);
            is_ball_moving_left = 1'b1;
            obj_found = tbl[r].f; obj_x = 10'(tbl[r].ox); obj_y = 10'(tbl[r].oy);
            obj_valid = tbl[r].v;
            pulses = 0;
            cycle();
            obj_valid = 1'b0;
            repeat (4) cycle();
            check($sformatf("row%0d_pulses", r), pulses, tbl[r].e_coll);
            check($sformatf("row%0d_speed", r), int'(estimated_speed), tbl[r].e_speed);
            check($sformatf("row%0d_valid", r), int'(speed_valid), tbl[r].e_valid);
        end

        // Reset while in cooldown after the last table hit.
        async_reset("rst_cool1");

        // Hit with a part-filled window, and the direction gate.
        ball_x = 10'd620; ball_y = 10'd20;
        frame(1, 100, 300);
        frame(1, 400, 300);
        frame(1, 100, 300);
        ball_x = 10'd100; ball_y = 10'd300;
        is_ball_moving_left = 1'b0;
        pulses = 0;
        repeat (3) cycle();
        check("dir_left0_pulses", pulses, GATE ? 0 : 1);
        is_ball_moving_left = 1'b1;
        pulses = 0;
        cycle();
        check("dir_left1_pulse", pulses, GATE ? 1 : 0);
        repeat (2) cycle();
        check("unfilled_speed", int'(estimated_speed), 1);
        check("unfilled_valid", int'(speed_valid), 0);

        // Reset mid-cooldown must re-arm immediately.
        async_reset("rst_cool2");
        pulses = 0;
        frame(1, 100, 300);
        check("rearm_after_reset", pulses, 1);

        // Randomised traffic checked against the model.
        async_reset("rst_rand");
        for (int i = 0; i < 3000; i++) begin
            obj_valid = ($urandom_range(0, 3) == 0);
            obj_found = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 7) == 0) begin
                obj_x = 10'($urandom_range(0, 639));
                obj_y = 10'($urandom_range(0, 479));
            end else begin
                obj_x = 10'(200 + $urandom_range(0, 80));
                obj_y = 10'(200 + $urandom_range(0, 80));
            end
            ball_x = 10'(200 + $urandom_range(0, 80));
            ball_y = 10'(200 + $urandom_range(0, 80));
            is_ball_moving_left = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
